// File: rtl/game_plot_arbiter_if.sv
// rtl/game_plot_arbiter_if.sv - Requester and game_plot engine signals of the plot arbiter
interface game_plot_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_plot;
    logic [4*N_REQ-1:0] req_x;
    logic [4*N_REQ-1:0] req_y;
    logic [3*N_REQ-1:0] req_colour;
    logic [N_REQ-1:0]   req_waitrequest;
    logic               gp_plot;
    logic [3:0]         gp_x;
    logic [3:0]         gp_y;
    logic [2:0]         gp_colour;
    logic               gp_waitrequest;
    logic [IDW-1:0]     grant_id;
    logic               arb_busy;

    modport master (
        output req_plot, req_x, req_y, req_colour, gp_waitrequest,
        input  req_waitrequest, gp_plot, gp_x, gp_y, gp_colour, grant_id, arb_busy
    );

    modport slave (
        input  req_plot, req_x, req_y, req_colour, gp_waitrequest,
        output req_waitrequest, gp_plot, gp_x, gp_y, gp_colour, grant_id, arb_busy
    );
endinterface

// File: rtl/game_plot_arbiter.sv
// rtl/game_plot_arbiter.sv - Shares one game_plot engine among N_REQ requesters
module game_plot_arbiter #(
    parameter int N_REQ = 4,
    parameter bit RR_EN = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    game_plot_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t           state;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   win;
    logic             win_valid;
    logic [3:0]       win_x;
    logic [3:0]       win_y;
    logic [2:0]       win_colour;
    logic             gp_plot;
    logic [3:0]       gp_x;
    logic [3:0]       gp_y;
    logic [2:0]       gp_colour;
    logic [N_REQ-1:0] waitreq;

    // Scan starts just past the last winner (round-robin) or at index 0 (fixed priority).
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        sum        = '0;
        idx        = '0;
        win        = '0;
        win_valid  = 1'b0;
        win_x      = '0;
        win_y      = '0;
        win_colour = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (RR_EN) begin
                sum = {1'b0, last} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(N_REQ))
                    sum = sum - (IDW+1)'(N_REQ);
                idx = sum[IDW-1:0];
            end else begin
                idx = IDW'(k - 1);
            end
            if (!win_valid && bus.req_plot[idx]) begin
                win_valid = 1'b1;
                win       = idx;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (win == IDW'(j)) begin
                win_x      = bus.req_x[4*j +: 4];
                win_y      = bus.req_y[4*j +: 4];
                win_colour = bus.req_colour[3*j +: 3];
            end
        end
    end

    always_comb begin
        waitreq = '1;
        if (rst_n && state == IDLE && win_valid)
            waitreq[win] = 1'b0;
    end

    // SETTLE absorbs the engine's one-cycle delay in raising waitrequest after an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gp_plot   <= 1'b0;
            gp_x      <= '0;
            gp_y      <= '0;
            gp_colour <= '0;
            grant_id  <= '0;
            last      <= IDW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gp_x      <= win_x;
                        gp_y      <= win_y;
                        gp_colour <= win_colour;
                        grant_id  <= win;
                        if (RR_EN)
                            last <= win;
                        gp_plot   <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.gp_waitrequest) begin
                        gp_plot <= 1'b0;
                        state   <= SETTLE;
                    end
                end
                SETTLE: state <= IDLE;
                default: begin
                    gp_plot <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_waitrequest = waitreq;
    assign bus.gp_plot         = gp_plot;
    assign bus.gp_x            = gp_x;
    assign bus.gp_y            = gp_y;
    assign bus.gp_colour       = gp_colour;
    assign bus.grant_id        = grant_id;
    assign bus.arb_busy        = (state != IDLE) || bus.gp_waitrequest;
endmodule
